mux_scan_ctrl: RTL and testbench

MUX_SCAN_CTRL -- requirements
Module: mux_scan_ctrl

---
 rtl/mux_scan_pkg.sv | 22 ++
 rtl/scan_timer.sv | 27 ++
 rtl/mux_scan_ctrl.sv | 210 +++++++++++++++++++++
 tb/tb_mux_scan_ctrl.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mux_scan_pkg.sv
// Shared types and constants for the multiplexed-channel ADC scan controller.
package mux_scan_pkg;

  localparam int CH_W   = 5;
  localparam int DATA_W = 12;

  localparam logic [DATA_W-1:0] ERR_SAMPLE = 12'hFFF;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SETTLE = 3'd1,
    ST_CONV   = 3'd2,
    ST_STORE  = 3'd3,
    ST_NEXT   = 3'd4
  } scan_state_t;

  // Channel numbers live on a 32-entry ring: 31 steps to 0.
  function automatic logic [CH_W-1:0] next_ch(input logic [CH_W-1:0] ch);
    return ch + CH_W'(1);
  endfunction

endpackage

// File: rtl/scan_timer.sv
// Loadable down-counter; expired is high whenever the count has reached zero.
module scan_timer #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         en,
  output logic         expired
);

  logic [W-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (load) begin
      cnt_q <= load_val;
    end else if (en && (cnt_q != '0)) begin
      cnt_q <= cnt_q - W'(1);
    end
  end

  assign expired = (cnt_q == '0);

endmodule

// File: rtl/mux_scan_ctrl.sv
// Scans a channel range through an analog mux: settle, convert, emit one sample per channel.
// Optional continuous mode (repeat until stop) is enabled by defining MUX_SCAN_CONTINUOUS_EN.
module mux_scan_ctrl
  import mux_scan_pkg::*;
#(
  parameter int SETTLE_CYC  = 64,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              stop,
  input  logic [CH_W-1:0]   ch_first,
  input  logic [CH_W-1:0]   ch_last,
  output logic [CH_W:0]     addr,
  output logic              adc_req,
  input  logic              adc_ack,
  input  logic [DATA_W-1:0] adc_data,
  output logic              smp_valid,
  output logic [CH_W-1:0]   smp_ch,
  output logic [DATA_W-1:0] smp_data,
  output logic              smp_err,
  output logic              busy,
  output logic              done,
  output scan_state_t       dbg_state
);

  localparam int TMR_MAX = (SETTLE_CYC > TIMEOUT_CYC) ? SETTLE_CYC : TIMEOUT_CYC;
  localparam int TMR_W   = $clog2(TMR_MAX + 1);
  // Timer expires when it reads zero, so loading N-1 yields N cycles in state.
  // SETTLE_CYC is loaded as-is to get the extra decoder-register cycle.
  localparam logic [TMR_W-1:0] SETTLE_LD  = TMR_W'(SETTLE_CYC);
  localparam logic [TMR_W-1:0] TIMEOUT_LD = TMR_W'(TIMEOUT_CYC - 1);

  scan_state_t       state_q, state_d;
  logic [CH_W-1:0]   ch_q, ch_d, first_q, last_q;
  logic              req_q;
  logic [CH_W-1:0]   smp_ch_q;
  logic [DATA_W-1:0] smp_data_q;
  logic              smp_err_q;

  logic              start_scan, ch_load, req_set, req_clr, smp_cap, smp_to, end_scan;
  logic              tmr_load, tmr_en, tmr_expired;
  logic [TMR_W-1:0]  tmr_val;
  logic              at_last, stop_hit;

`ifdef MUX_SCAN_CONTINUOUS_EN
  localparam bit CONT_EN = 1'b1;
  logic stop_pend_q;

  // A stop seen anywhere in a scan is held until the current channel finishes.
  always_ff @(posedge clk) begin
    if (rst) begin
      stop_pend_q <= 1'b0;
    end else if (state_q == ST_IDLE) begin
      stop_pend_q <= 1'b0;
    end else if (stop) begin
      stop_pend_q <= 1'b1;
    end
  end

  assign stop_hit = stop_pend_q | stop;
`else
  localparam bit CONT_EN = 1'b0;
  logic unused_stop;

  assign unused_stop = stop;
  assign stop_hit    = 1'b0;
`endif

  assign at_last = (ch_q == last_q);
  assign tmr_en  = (state_q == ST_SETTLE) || (state_q == ST_CONV);

  scan_timer #(.W(TMR_W)) u_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (tmr_load),
    .load_val (tmr_val),
    .en       (tmr_en),
    .expired  (tmr_expired)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    start_scan = 1'b0;
    ch_load    = 1'b0;
    ch_d       = ch_q;
    tmr_load   = 1'b0;
    tmr_val    = '0;
    req_set    = 1'b0;
    req_clr    = 1'b0;
    smp_cap    = 1'b0;
    smp_to     = 1'b0;
    end_scan   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          start_scan = 1'b1;
          ch_load    = 1'b1;
          ch_d       = ch_first;
          tmr_load   = 1'b1;
          tmr_val    = SETTLE_LD;
          state_d    = ST_SETTLE;
        end
      end
      ST_SETTLE: begin
        if (tmr_expired) begin
          req_set  = 1'b1;
          tmr_load = 1'b1;
          tmr_val  = TIMEOUT_LD;
          state_d  = ST_CONV;
        end
      end
      ST_CONV: begin
        // An ack arriving on the timeout cycle still counts as a good sample.
        if (adc_ack) begin
          req_clr = 1'b1;
          smp_cap = 1'b1;
          state_d = ST_STORE;
        end else if (tmr_expired) begin
          req_clr = 1'b1;
          smp_to  = 1'b1;
          state_d = ST_STORE;
        end
      end
      ST_STORE: begin
        state_d = ST_NEXT;
      end
      ST_NEXT: begin
        if (stop_hit) begin
          end_scan = 1'b1;
          state_d  = ST_IDLE;
        end else if (at_last) begin
          end_scan = 1'b1;
          if (CONT_EN) begin
            ch_load  = 1'b1;
            ch_d     = first_q;
            tmr_load = 1'b1;
            tmr_val  = SETTLE_LD;
            state_d  = ST_SETTLE;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          ch_load  = 1'b1;
          ch_d     = next_ch(ch_q);
          tmr_load = 1'b1;
          tmr_val  = SETTLE_LD;
          state_d  = ST_SETTLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ch_q       <= '0;
      first_q    <= '0;
      last_q     <= '0;
      req_q      <= 1'b0;
      smp_ch_q   <= '0;
      smp_data_q <= '0;
      smp_err_q  <= 1'b0;
    end else begin
      if (start_scan) begin
        first_q <= ch_first;
        last_q  <= ch_last;
      end
      if (ch_load) begin
        ch_q <= ch_d;
      end
      if (req_set) begin
        req_q <= 1'b1;
      end else if (req_clr) begin
        req_q <= 1'b0;
      end
      if (smp_cap) begin
        smp_ch_q   <= ch_q;
        smp_data_q <= adc_data;
        smp_err_q  <= 1'b0;
      end else if (smp_to) begin
        smp_ch_q   <= ch_q;
        smp_data_q <= ERR_SAMPLE;
        smp_err_q  <= 1'b1;
      end
    end
  end

  assign addr      = {1'b0, ch_q};
  assign adc_req   = req_q;
  assign smp_valid = (state_q == ST_STORE);
  assign smp_ch    = smp_ch_q;
  assign smp_data  = smp_data_q;
  assign smp_err   = smp_err_q;
  assign busy      = (state_q != ST_IDLE);
  assign done      = end_scan;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_mux_scan_ctrl.sv
// Directed-plus-random bench for mux_scan_ctrl with an ADC responder and a channel-list reference model.
`timescale 1ns/1ps
module tb_mux_scan_ctrl;
  import mux_scan_pkg::*;

  localparam int SETTLE = 4;
  localparam int TMO    = 16;

  logic        clk = 1'b0;
  logic        rst, start, stop;
  logic [4:0]  ch_first, ch_last;
  logic [5:0]  addr;
  logic        adc_req, adc_ack;
  logic [11:0] adc_data;
  logic        smp_valid;
  logic [4:0]  smp_ch;
  logic [11:0] smp_data;
  logic        smp_err, busy, done;
  scan_state_t dbg_state;

  mux_scan_ctrl #(.SETTLE_CYC(SETTLE), .TIMEOUT_CYC(TMO)) dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop),
    .ch_first(ch_first), .ch_last(ch_last), .addr(addr),
    .adc_req(adc_req), .adc_ack(adc_ack), .adc_data(adc_data),
    .smp_valid(smp_valid), .smp_ch(smp_ch), .smp_data(smp_data),
    .smp_err(smp_err), .busy(busy), .done(done), .dbg_state(dbg_state)
  );

  // Clock
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Observations and reference data
  int          cyc = 0, chg_cyc = 0, done_cnt = 0, addr5_bad = 0;
  logic [5:0]  prev_addr = '0;
  logic        prev_busy = 1'b0, prev_req = 1'b0;
  logic [17:0] obs_q[$];
  logic [17:0] exp_q[$];
  logic [11:0] sent_q[$];
  logic [4:0]  exp_ch_q[$];
  int          gap_q[$];

  // ADC responder config: 0 never acks, 1 fixed delay, 2 random delay
  int ack_mode = 1;
  int ack_fix  = 3;
  bit spurious = 1'b0;

  always @(negedge clk) begin
    cyc++;
    if (!rst) begin
      if (smp_valid) obs_q.push_back({smp_err, smp_ch, smp_data});
      if (done) done_cnt++;
      if (addr[5]) addr5_bad++;
      if (addr != prev_addr || (busy && !prev_busy)) chg_cyc = cyc;
      if (adc_req && !prev_req) gap_q.push_back(cyc - chg_cyc);
    end
    prev_addr = addr;
    prev_busy = busy;
    prev_req  = adc_req;
  end

  // ADC responder driver
  initial begin
    int age;
    int dly;
    adc_ack = 1'b0; adc_data = '0; age = 0; dly = 0;
    forever begin
      @(negedge clk);
      adc_ack = 1'b0;
      if (adc_req && !rst) begin
        age++;
        if (age == 1) dly = (ack_mode == 2) ? int'($urandom_range(1, 6)) : ack_fix;
        if (ack_mode != 0 && age == dly) begin
          adc_data = 12'($urandom_range(0, 12'hFFE));
          adc_ack  = 1'b1;
          sent_q.push_back(adc_data);
        end
      end else begin
        age = 0;
        if (spurious && $urandom_range(0, 3) == 0) begin
          adc_data = 12'hABC;
          adc_ack  = 1'b1;
        end
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: a pass visits first, first+1 (mod 32), ... up to and including last.
  task automatic add_pass(input int first, input int last);
    int ch;
    ch = first;
    forever begin
      exp_ch_q.push_back(5'(ch));
      if (ch == last) break;
      ch = (ch + 1) % 32;
    end
  endtask

  task automatic pulse_start(input int f, input int l);
    ch_first = 5'(f);
    ch_last  = 5'(l);
    start    = 1'b1;
    step(1);
    start    = 1'b0;
  endtask

  task automatic wait_idle(input string tag, input int budget);
    int n;
    n = 0;
    while (busy === 1'b1 && n < budget) begin
      step(1);
      n++;
    end
    check({tag, "_idle_in_budget"}, 32'(n < budget), 32'd1);
  endtask

  task automatic verify(input string tag, input bit tmo, input int done0, input int exp_done);
    logic [11:0] d;
    exp_q.delete();
    foreach (exp_ch_q[i]) begin
      if (tmo) d = ERR_SAMPLE;
      else if (sent_q.size() > 0) d = sent_q.pop_front();
      else d = 12'h000;
      exp_q.push_back({tmo, exp_ch_q[i], d});
    end
    check({tag, "_count"}, 32'(obs_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++)
      check($sformatf("%s_smp%0d", tag, i), 32'(obs_q[i]), 32'(exp_q[i]));
    check({tag, "_nreq"}, 32'(gap_q.size()), 32'(exp_q.size()));
    foreach (gap_q[i]) check($sformatf("%s_settle%0d", tag, i), 32'(gap_q[i]), 32'(SETTLE + 1));
    check({tag, "_done"}, 32'(done_cnt - done0), 32'(exp_done));
    check({tag, "_addr5"}, 32'(addr5_bad), 32'd0);
    obs_q.delete(); gap_q.delete(); exp_ch_q.delete(); sent_q.delete();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int d0, n, f, l;
    rst = 1'b1; start = 1'b0; stop = 1'b0; ch_first = '0; ch_last = '0;
    step(3);
    check("rst_addr", 32'(addr), 32'd0);
    check("rst_req", 32'(adc_req), 32'd0);
    check("rst_valid", 32'(smp_valid), 32'd0);
    check("rst_ch", 32'(smp_ch), 32'd0);
    check("rst_data", 32'(smp_data), 32'd0);
    check("rst_err", 32'(smp_err), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    rst = 1'b0;
    step(2);

    // Single pass 2..5, ack 3 cycles after req, spurious acks while req is low
    ack_mode = 1; ack_fix = 3; spurious = 1'b1;
    d0 = done_cnt; add_pass(2, 5);
    pulse_start(2, 5);
    wait_idle("pass_2_5", 400);
    verify("pass_2_5", 1'b0, d0, 1);
    check("pass_2_5_addr_hold", 32'(addr), 32'd5);

    // Wrap 30..1 with random ack delays; a start while busy must be ignored
    ack_mode = 2;
    d0 = done_cnt; add_pass(30, 1);
    pulse_start(30, 1);
    step(8);
    pulse_start(10, 12);
    wait_idle("wrap", 400);
    verify("wrap", 1'b0, d0, 1);
    check("wrap_addr_hold", 32'(addr), 32'd1);

    // ADC never acks: each channel times out, scan still proceeds
    ack_mode = 0;
    d0 = done_cnt; add_pass(7, 8);
    pulse_start(7, 8);
    wait_idle("timeout", 400);
    verify("timeout", 1'b1, d0, 1);

    // first == last scans exactly one channel
    ack_mode = 1; ack_fix = 2;
    d0 = done_cnt; add_pass(9, 9);
    pulse_start(9, 9);
    wait_idle("single", 200);
    verify("single", 1'b0, d0, 1);

    // Random ranges and random ack delays
    ack_mode = 2;
    for (int it = 0; it < 4; it++) begin
      f = int'($urandom_range(0, 31));
      l = (f + int'($urandom_range(0, 5))) % 32;
      d0 = done_cnt; add_pass(f, l);
      pulse_start(f, l);
`ifndef MUX_SCAN_CONTINUOUS_EN
      step(3);
      stop = 1'b1; step(1); stop = 1'b0;
`endif
      wait_idle($sformatf("rand%0d", it), 600);
      verify($sformatf("rand%0d", it), 1'b0, d0, 1);
    end

    // Reset while a conversion is outstanding
    ack_mode = 0;
    d0 = done_cnt;
    pulse_start(3, 6);
    n = 0;
    while (adc_req !== 1'b1 && n < 50) begin step(1); n++; end
    check("rstconv_req_seen", 32'(n < 50), 32'd1);
    step(3);
    rst = 1'b1;
    step(1);
    check("rstconv_req", 32'(adc_req), 32'd0);
    check("rstconv_busy", 32'(busy), 32'd0);
    check("rstconv_valid", 32'(smp_valid), 32'd0);
    rst = 1'b0;
    step(40);
    check("rstconv_no_smp", 32'(obs_q.size()), 32'd0);
    check("rstconv_no_done", 32'(done_cnt - d0), 32'd0);
    obs_q.delete(); gap_q.delete(); sent_q.delete();

`ifdef MUX_SCAN_CONTINUOUS_EN
    // Continuous 0..1 until stop during ch1 settle
    ack_mode = 1; ack_fix = 2;
    d0 = done_cnt;
    pulse_start(0, 1);
    n = 0;
    while (obs_q.size() < 5 && n < 500) begin step(1); n++; end
    n = 0;
    while (!(addr == 6'd1 && adc_req == 1'b0) && n < 50) begin step(1); n++; end
    check("cont_reach_ch1", 32'(n < 50), 32'd1);
    stop = 1'b1; step(1); stop = 1'b0;
    wait_idle("cont", 200);
    add_pass(0, 1); add_pass(0, 1); add_pass(0, 1);
    verify("cont", 1'b0, d0, 3);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
